imem_loader: RTL and testbench

//  Boot-time program loader; the writing side of the instruction memory.

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/le_word_assembler.sv | 50 +++++
 rtl/imem_loader.sv | 176 +++++++++++++++++
 tb/tb_imem_loader.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
//   state_e         : loader FSM states
//   AckByte/NakByte : host reply codes
//   MaxWordsDefault : highest legal image word count (loader region lies above it)
package imem_loader_pkg;

  typedef enum logic [2:0] {
    StLen,
    StData,
    StSum,
    StAck,
    StDone
  } state_e;

  localparam logic [7:0] AckByte = 8'hAA;
  localparam logic [7:0] NakByte = 8'h55;

  localparam int unsigned MaxWordsDefault = 16359;

endpackage

// File: rtl/le_word_assembler.sv
// Little-endian byte-to-word assembler.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   clear_i        : drop any partial word and restart at byte 0 (wins over byte_valid_i)
//   byte_valid_i   : byte_i is valid this cycle
//   byte_i         : incoming byte; first byte of a word lands in bits [7:0]
//   word_valid_o   : combinational pulse in the cycle the 4th byte arrives
//   word_o         : completed word, valid with word_valid_o
module le_word_assembler (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] buf_q, buf_d;

  always_comb begin
    cnt_d        = cnt_q;
    buf_d        = buf_q;
    word_valid_o = 1'b0;
    // The top byte is taken straight from the input so the word is ready on the 4th byte.
    word_o       = {byte_i, buf_q};
    if (clear_i) begin
      cnt_d = 2'd0;
    end else if (byte_valid_i) begin
      case (cnt_q)
        2'd0:    buf_d[7:0]   = byte_i;
        2'd1:    buf_d[15:8]  = byte_i;
        2'd2:    buf_d[23:16] = byte_i;
        default: word_valid_o = 1'b1;
      endcase
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 2'd0;
      buf_q <= 24'd0;
    end else begin
      cnt_q <= cnt_d;
      buf_q <= buf_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time program loader: writing side of the instruction memory.
// Frame from the host: 4-byte word count N, N words, 4-byte checksum (all little-endian).
//   clk, rst               : clock, synchronous active-high reset
//   rx_data, rx_valid      : byte stream from the UART receiver
//   restart                : abort / leave DONE and accept a new image
//   tx_ready               : UART transmitter can take a byte
//   tx_data, tx_valid      : ACK/NAK reply, held until tx_ready
//   imem_we/addr/wdata     : single-word imem write port
//   load_done              : valid image loaded; core may run
//   load_err               : last frame was NAKed (clears on first byte of the next frame)
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned MAX_WORDS = MaxWordsDefault,
  parameter logic [7:0]  ACK_BYTE  = AckByte,
  parameter logic [7:0]  NAK_BYTE  = NakByte
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              restart,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              load_done,
  output logic              load_err
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   n_q, n_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [31:0]         sum_q, sum_d;
  logic [7:0]          reply_q, reply_d;
  logic                tx_valid_q, tx_valid_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                byte_take;
  logic                word_valid;
  logic [31:0]         word;

  // Bytes are only consumed while parsing a frame; restart drops a coincident byte.
  assign byte_take = rx_valid && !restart &&
                     ((state_q == StLen) || (state_q == StData) || (state_q == StSum));

  le_word_assembler u_asm (
    .clk_i        (clk),
    .rst_i        (rst),
    .clear_i      (restart),
    .byte_valid_i (byte_take),
    .byte_i       (rx_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    reply_d    = reply_q;
    tx_valid_d = tx_valid_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    done_d     = done_q;
    err_d      = err_q;

    if (restart) begin
      // Abort whatever is in flight; words already written stay in imem.
      state_d    = StLen;
      n_d        = '0;
      idx_d      = '0;
      sum_d      = 32'd0;
      tx_valid_d = 1'b0;
      done_d     = 1'b0;
    end else begin
      unique case (state_q)
        StLen: begin
          if (byte_take) err_d = 1'b0;
          if (word_valid) begin
            if (word > MAX_WORDS) begin
              reply_d    = NAK_BYTE;
              tx_valid_d = 1'b1;
              state_d    = StAck;
            end else if (word == 32'd0) begin
              state_d = StSum;
            end else begin
              n_d     = word[ADDR_W-1:0];
              state_d = StData;
            end
          end
        end
        StData: begin
          if (word_valid) begin
            we_d    = 1'b1;
            addr_d  = idx_q;
            wdata_d = word;
            sum_d   = sum_q + word;
            idx_d   = idx_q + ADDR_W'(1);
            if (idx_q == n_q - ADDR_W'(1)) state_d = StSum;
          end
        end
        StSum: begin
          if (word_valid) begin
            reply_d    = (word == sum_q) ? ACK_BYTE : NAK_BYTE;
            tx_valid_d = 1'b1;
            state_d    = StAck;
          end
        end
        StAck: begin
          if (tx_ready) begin
            tx_valid_d = 1'b0;
            if (reply_q == ACK_BYTE) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else begin
              state_d = StLen;
              err_d   = 1'b1;
              n_d     = '0;
              idx_d   = '0;
              sum_d   = 32'd0;
            end
          end
        end
        StDone: ;
        default: state_d = StLen;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StLen;
      n_q        <= '0;
      idx_q      <= '0;
      sum_q      <= 32'd0;
      reply_q    <= 8'd0;
      tx_valid_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      reply_q    <= reply_d;
      tx_valid_q <= tx_valid_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign tx_data    = reply_q;
  assign tx_valid   = tx_valid_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign load_done  = done_q;
  assign load_err   = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: drives framed images and checks writes and replies.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        restart;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        imem_we;
  logic [13:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        load_done;
  logic        load_err;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  logic [45:0] wr_q[$];
  logic [7:0]  tx_q[$];

  imem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .restart    (restart),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  // Record every write strobe and every completed reply handshake as the DUT sees them.
  always @(posedge clk) begin
    if (imem_we) wr_q.push_back({imem_addr, imem_wdata});
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // All stimulus tasks start and end on a falling edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8]);
    end
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic expect_tx(input string tag, input logic [7:0] exp);
    logic [7:0] b;
    for (int i = 0; i < 100 && tx_q.size() == 0; i++) @(negedge clk);
    if (tx_q.size() == 0) begin
      check_val({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      b = tx_q.pop_front();
      check_val(tag, {24'd0, b}, {24'd0, exp});
    end
  endtask

  task automatic expect_wr(input string tag, input logic [13:0] addr, input logic [31:0] data);
    logic [45:0] e;
    if (wr_q.size() == 0) begin
      check_val({tag, "_missing"}, 32'd0, 32'd1);
    end else begin
      e = wr_q.pop_front();
      check_val({tag, "_addr"}, {18'd0, e[45:32]}, {18'd0, addr});
      check_val({tag, "_data"}, e[31:0], data);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_tx_valid"},  {31'd0, tx_valid},  32'd0);
    check_val({tag, "_tx_data"},   {24'd0, tx_data},   32'd0);
    check_val({tag, "_imem_we"},   {31'd0, imem_we},   32'd0);
    check_val({tag, "_imem_addr"}, {18'd0, imem_addr}, 32'd0);
    check_val({tag, "_imem_wdata"}, imem_wdata,        32'd0);
    check_val({tag, "_load_done"}, {31'd0, load_done}, 32'd0);
    check_val({tag, "_load_err"},  {31'd0, load_err},  32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    rx_data  = 8'd0;
    rx_valid = 1'b0;
    restart  = 1'b0;
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // 1: two-word image with matching checksum (0x11223344 + 0xDEADBEEF).
    send_word(32'd2);
    send_word(32'h11223344);
    send_word(32'hDEADBEEF);
    send_word(32'hEFCFF233);
    expect_tx("t1_tx", 8'hAA);
    expect_wr("t1_w0", 14'd0, 32'h11223344);
    expect_wr("t1_w1", 14'd1, 32'hDEADBEEF);
    check_val("t1_nwr", wr_q.size(), 32'd0);
    check_val("t1_done", {31'd0, load_done}, 32'd1);

    // 2: bad checksum -> NAK, word still written, back in LEN with load_err.
    pulse_restart();
    check_val("t2_done_drop", {31'd0, load_done}, 32'd0);
    send_word(32'd1);
    send_word(32'h00000001);
    send_word(32'h00000002);
    expect_tx("t2_tx", 8'h55);
    expect_wr("t2_w0", 14'd0, 32'h00000001);
    check_val("t2_err", {31'd0, load_err}, 32'd1);
    check_val("t2_done", {31'd0, load_done}, 32'd0);

    // 3: count one above the legal maximum -> NAK, no writes; then empty image.
    send_word(32'd16360);
    expect_tx("t3_tx_big", 8'h55);
    check_val("t3_nwr_big", wr_q.size(), 32'd0);
    send_byte(8'h00);
    check_val("t3_err_clr", {31'd0, load_err}, 32'd0);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_word(32'd0);
    expect_tx("t3_tx_empty", 8'hAA);
    check_val("t3_done", {31'd0, load_done}, 32'd1);
    check_val("t3_nwr", wr_q.size(), 32'd0);

    // 4: reply held while the transmitter is busy; bytes sent meanwhile are ignored.
    pulse_restart();
    tx_ready = 1'b0;
    send_word(32'd1);
    send_word(32'h12345678);
    send_word(32'h12345678);
    for (int i = 0; i < 10; i++) begin
      rx_data  = 8'hFF;
      rx_valid = 1'b1;
      check_val("t4_hold_valid", {31'd0, tx_valid}, 32'd1);
      check_val("t4_hold_data", {24'd0, tx_data}, 32'h000000AA);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    check_val("t4_no_xfer", tx_q.size(), 32'd0);
    tx_ready = 1'b1;
    expect_tx("t4_tx", 8'hAA);
    expect_wr("t4_w0", 14'd0, 32'h12345678);
    check_val("t4_done", {31'd0, load_done}, 32'd1);

    // 5: reset in the middle of word 3, then a fresh frame.
    pulse_restart();
    send_word(32'd4);
    send_word(32'hA0A0A0A0);
    send_word(32'hA1A1A1A1);
    send_word(32'hA2A2A2A2);
    send_byte(8'h33);
    send_byte(8'h44);
    check_val("t5_nwr_pre", wr_q.size(), 32'd3);
    wr_q.delete();
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("t5_rst");
    rst = 1'b0;
    send_word(32'd2);
    send_word(32'h0BADF00D);
    send_word(32'h00C0FFEE);
    send_word(32'h0C6EEFFB);
    expect_tx("t5_tx", 8'hAA);
    expect_wr("t5_w0", 14'd0, 32'h0BADF00D);
    expect_wr("t5_w1", 14'd1, 32'h00C0FFEE);
    check_val("t5_done", {31'd0, load_done}, 32'd1);

    // 6: restart and a byte together in DONE; the byte must not start the count.
    restart  = 1'b1;
    rx_data  = 8'h07;
    rx_valid = 1'b1;
    @(negedge clk);
    restart  = 1'b0;
    rx_valid = 1'b0;
    check_val("t6_done_drop", {31'd0, load_done}, 32'd0);
    send_word(32'd1);
    send_word(32'hCAFEF00D);
    send_word(32'hCAFEF00D);
    expect_tx("t6_tx", 8'hAA);
    expect_wr("t6_w0", 14'd0, 32'hCAFEF00D);
    check_val("t6_nwr", wr_q.size(), 32'd0);
    check_val("t6_done", {31'd0, load_done}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
